// File: rtl/bcd_pkg.sv
// Shared types and constants for the decimal key-entry controller and its encoder.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] KEY_INVALID = 4'd15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    EMIT     = 3'd2,
    WAIT_REL = 3'd3,
    ERRST    = 3'd4
  } state_e;

endpackage

// File: rtl/bcd_key_entry_enc.sv
// One-hot to BCD encoder: returns the index of the single set bit, KEY_INVALID otherwise.
module bcd_key_entry_enc
  import bcd_pkg::*;
(
  input  logic [9:0]       onehot,
  output logic [BCD_W-1:0] code
);

  logic [3:0] hits;
  logic [3:0] idx;

  always_comb begin
    hits = 4'd0;
    idx  = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (onehot[k]) begin
        hits = hits + 4'd1;
        idx  = 4'(k);
      end
    end
    // Zero or several keys both map to the reject code.
    code = (hits == 4'd1) ? idx : KEY_INVALID;
  end

endmodule

// File: rtl/bcd_key_entry.sv
// 10-key decimal entry: synchronise, debounce, reject multi-key presses,
// hand the digit out over valid/ready and shift it into a BCD display register.
module bcd_key_entry
  import bcd_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int NDIG      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            sw,
  input  logic                  clr,
  input  logic                  key_ready,
  output logic                  key_valid,
  output logic [BCD_W-1:0]      key_code,
  output logic [BCD_W*NDIG-1:0] digits,
  output logic                  err
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [9:0]            sync1_q, sw_s_q;
  state_e                state_q, state_d;
  logic [9:0]            snap_q, snap_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BCD_W*NDIG-1:0] digits_q, digits_d;
  logic [BCD_W-1:0]      key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  err_q, err_d;
  logic [BCD_W-1:0]      enc_code;

  bcd_key_entry_enc u_enc (
    .onehot (snap_q),
    .code   (enc_code)
  );

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (sw_s_q != 10'd0) begin
          state_d = DEBOUNCE;
          snap_d  = sw_s_q;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (sw_s_q == 10'd0) begin
          state_d = IDLE;
        end else if (sw_s_q != snap_q) begin
          snap_d = sw_s_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          if (enc_code == KEY_INVALID) begin
            state_d = ERRST;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d     = EMIT;
            key_code_d  = enc_code;
            key_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EMIT: begin
        // Switch activity is ignored here so a quick release cannot cancel the key.
        if (key_valid_q && key_ready) begin
          key_valid_d = 1'b0;
          digits_d    = {digits_q[BCD_W*NDIG-BCD_W-1:0], key_code_q};
          state_d     = WAIT_REL;
          cnt_d       = '0;
        end
      end
      WAIT_REL, ERRST: begin
        if (sw_s_q != 10'd0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      digits_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sw_s_q      <= '0;
      state_q     <= IDLE;
      snap_q      <= '0;
      cnt_q       <= '0;
      digits_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= sw;
      sw_s_q      <= sync1_q;
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digits    = digits_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Self-checking bench for bcd_key_entry: directed table, corner sequences, random stimulus vs. run-length model.
module tb_bcd_key_entry;
  localparam int DB   = 4;
  localparam int NDIG = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] sw = '0;
  logic clr = 1'b0;
  logic key_ready = 1'b0;
  logic key_valid;
  logic [3:0] key_code;
  logic [4*NDIG-1:0] digits;
  logic err;

  int checks = 0;
  int failures = 0;

  bcd_key_entry #(.DB_CYCLES(DB), .NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .clr(clr), .key_ready(key_ready),
    .key_valid(key_valid), .key_code(key_code), .digits(digits), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: phases plus run lengths of the synchronised switch value.
  typedef enum {ARMED, OFFER, RELEASE} phase_t;
  phase_t     m_phase;
  logic [9:0] m_s1, m_ss, m_run_val;
  int         m_run_len, m_zero_len, m_digits;
  logic       m_valid, m_err;
  logic [3:0] m_code;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int enc(logic [9:0] v);
    if ($countones(v) != 1) return 15;
    for (int k = 0; k < 10; k++) if (v == (10'd1 << k)) return k;
    return 15;
  endfunction

  task automatic model_reset();
    m_phase = ARMED; m_s1 = '0; m_ss = '0; m_run_val = '0;
    m_run_len = 0; m_zero_len = 0; m_digits = 0;
    m_valid = 1'b0; m_err = 1'b0; m_code = '0;
  endtask

  task automatic model_step();
    logic [9:0] seen;
    seen = m_ss;
    case (m_phase)
      ARMED: begin
        if (seen == 10'd0) m_run_len = 0;
        else begin
          if (m_run_len > 0 && seen == m_run_val) m_run_len++;
          else begin m_run_val = seen; m_run_len = 1; end
          if (m_run_len == DB + 1) begin
            if (enc(seen) == 15) begin m_err = 1'b1; m_phase = RELEASE; end
            else begin m_valid = 1'b1; m_code = 4'(enc(seen)); m_phase = OFFER; end
            m_zero_len = 0; m_run_len = 0;
          end
        end
      end
      OFFER: begin
        if (key_ready) begin
          m_valid = 1'b0;
          m_digits = (m_digits * 16 + int'(m_code)) % 65536;
          m_phase = RELEASE; m_zero_len = 0;
        end
      end
      RELEASE: begin
        if (seen != 10'd0) m_zero_len = 0;
        else begin
          m_zero_len++;
          if (m_zero_len == DB) begin m_phase = ARMED; m_err = 1'b0; m_run_len = 0; end
        end
      end
    endcase
    if (clr) m_digits = 0;
    m_ss = m_s1;
    m_s1 = sw;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    chk("key_valid", key_valid, m_valid);
    chk("key_code", key_code, m_code);
    chk("digits", digits, m_digits[15:0]);
    chk("err", err, m_err);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (key_valid) begin n = i; break; end
    end
    checks++;
    if (n == 0) begin failures++; $display("FAIL wait_valid timeout t=%0t", $time); end
  endtask

  task automatic idle(int n);
    sw = '0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  typedef struct {
    logic [9:0] sw;
    int         hold;
    int         exp;   // code 0..9, 15 = reject, -1 = nothing
  } vec_t;

  initial begin
    vec_t tbl[7];
    int n, res, rises;
    logic prev;
    model_reset();

    // Reset held with a toggling key: nothing may come out.
    for (int i = 0; i < 6; i++) begin sw = sw ^ 10'h004; cyc(); end
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_digits", digits, 16'h0000);
    rst_n = 1'b1; key_ready = 1'b1;
    idle(20);
    chk("quiet_valid", key_valid, 1'b0);

    // Latency: 7 edges from press to KEY_VALID, single-cycle pulse with ready high.
    sw = 10'h008;
    wait_valid(n);
    chk("latency_edges", n, 7);
    chk("lat_code", key_code, 4'd3);
    for (int i = 0; i < 4; i++) cyc();
    chk("lat_pulse_low", key_valid, 1'b0);
    chk("lat_digits", digits, 16'h0003);
    idle(10);

    tbl[0] = '{10'h001, 10, 0};
    tbl[1] = '{10'h200, 10, 9};
    tbl[2] = '{10'h011, 10, 15};
    tbl[3] = '{10'h300, 10, 15};
    tbl[4] = '{10'h040, 4, -1};
    tbl[5] = '{10'h080, 5, 7};
    tbl[6] = '{10'h010, 12, 4};
    for (int t = 0; t < 7; t++) begin
      res = -1;
      sw = tbl[t].sw;
      for (int i = 0; i < tbl[t].hold + 12; i++) begin
        if (i == tbl[t].hold) sw = '0;
        cyc();
        if (key_valid) res = int'(key_code);
        else if (err && res == -1) res = 15;
      end
      chk($sformatf("table%0d", t), res, tbl[t].exp);
    end
    chk("table_digits", digits, 16'h0974);

    // Bouncing key: exactly one emission.
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 22; i++) begin
      sw = (i < 10) ? (((i / 2) % 2 == 0) ? 10'h020 : 10'h000) : 10'h020;
      cyc();
      if (key_valid && !prev) begin rises++; chk("bounce_code", key_code, 4'd5); end
      prev = key_valid;
    end
    chk("bounce_count", rises, 1);
    idle(10);

    // Keys 1..5, consumer stalls on key 2 and the key is released while stalled.
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      key_ready = (k != 2);
      sw = 10'd1 << k;
      wait_valid(n);
      if (k == 2) begin
        for (int i = 0; i < 5; i++) begin
          chk("stall_valid", key_valid, 1'b1);
          chk("stall_code", key_code, 4'd2);
          if (i == 2) sw = '0;
          cyc();
        end
        key_ready = 1'b1;
        cyc();
      end
      idle(10);
    end
    chk("seq_digits", digits, 16'h2345);

    // CLR on the accept edge.
    key_ready = 1'b0; sw = 10'h040;
    wait_valid(n);
    clr = 1'b1; key_ready = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_acc_valid", key_valid, 1'b0);
    chk("clr_acc_digits", digits, 16'h0000);
    idle(10);

    // Asynchronous reset while a key is on offer.
    key_ready = 1'b0; sw = 10'h002;
    wait_valid(n);
    clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", key_valid, 1'b0);
    chk("async_digits", digits, 16'h0000);
    chk("async_code", key_code, 4'd0);
    model_reset();
    sw = '0;
    cyc(); cyc();
    rst_n = 1'b1; key_ready = 1'b1;
    idle(8);

    // Random segments against the model.
    for (int s = 0; s < 400; s++) begin
      int r, len;
      r = $urandom_range(0, 99);
      if (r < 40) sw = '0;
      else if (r < 85) sw = 10'd1 << $urandom_range(0, 9);
      else sw = 10'($urandom);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        key_ready = ($urandom_range(0, 9) < 7);
        clr = ($urandom_range(0, 49) == 0);
        cyc();
      end
    end
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
